// File: rtl/logic_reducer_pkg.sv
// Shared types for the logic_reducer slice: operator and FSM state encodings,
// plus the identity element used to seed a fresh reduction group.
package logic_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {
    OP_OR   = 2'd0,
    OP_AND  = 2'd1,
    OP_XOR  = 2'd2,
    OP_PASS = 2'd3
  } op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Identity at the widest supported width; callers size-cast to their N.
  function automatic logic [MAX_W-1:0] op_identity(op_e op);
    return (op == OP_AND) ? {MAX_W{1'b1}} : {MAX_W{1'b0}};
  endfunction

endpackage

// File: rtl/logic_alu.sv
// Combinational two-operand bitwise operator; PASS forwards x.
module logic_alu
  import logic_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [1:0]   op,
  output logic [N-1:0] z
);

  always_comb begin
    // NOTE: default first so every path assigns z and no latch is inferred.
    z = x;
    case (op_e'(op))
      OP_OR:   z = x | y;
      OP_AND:  z = x & y;
      OP_XOR:  z = x ^ y;
      OP_PASS: z = x;
      default: z = x;
    endcase
  end

endmodule

// File: rtl/logic_reducer.sv
// Registered bitwise logic unit with valid/ready handshakes; optionally folds
// BEATS accepted beats (or fewer, on flush) into one result.
module logic_reducer
  import logic_pkg::*;
#(
  parameter int N     = 4,
  parameter int BEATS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   op,
  input  logic         acc_en,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] q
);

  localparam int CW = $clog2(BEATS + 1);

  state_e        state;
  logic [N-1:0]  acc;
  logic [CW-1:0] cnt;
  logic [1:0]    grp_op;

  logic          can_load;
  logic          accept;
  logic          acc_mode;
  op_e           eff_op;
  logic [N-1:0]  r;
  logic [N-1:0]  acc_base;
  logic [N-1:0]  acc_next;
  logic [CW-1:0] cnt_next;
  logic          last_beat;
  logic          flush_now;
  logic          emit;
  logic [N-1:0]  result;

  assign can_load = !out_valid || out_ready;
  assign in_ready = rst && can_load;
  assign accept   = in_valid && in_ready;

  // An open group is locked to the operator and mode it started with.
  assign eff_op   = op_e'((state == ACCUM) ? grp_op : op);
  assign acc_mode = (state == ACCUM) || acc_en;

  logic_alu #(.N(N)) u_beat (
    .x  (a),
    .y  (b),
    .op (eff_op),
    .z  (r)
  );

  // r is the x operand so PASS keeps the latest a; the other ops commute.
  assign acc_base = (state == IDLE) ? N'(op_identity(eff_op)) : acc;

  logic_alu #(.N(N)) u_fold (
    .x  (r),
    .y  (acc_base),
    .op (eff_op),
    .z  (acc_next)
  );

  assign cnt_next  = cnt + CW'(1);
  assign last_beat = accept && acc_mode && (cnt_next == CW'(BEATS));
  assign flush_now = (state == ACCUM) && flush && can_load;
  assign emit      = (accept && !acc_mode) || last_beat || flush_now;
  assign result    = !acc_mode ? r : (accept ? acc_next : acc);

  // NOTE: non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      // NOTE: acc is a plain register, not a memory, so it joins the async reset.
      acc       <= '0;
      cnt       <= '0;
      grp_op    <= 2'(OP_OR);
      q         <= '0;
      out_valid <= 1'b0;
    end else begin
      if (emit) begin
        q         <= result;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept && acc_en) begin
            acc    <= acc_next;
            grp_op <= op;
            if (last_beat) begin
              cnt <= '0;
            end else begin
              cnt   <= cnt_next;
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc <= acc_next;
            cnt <= cnt_next;
          end
          if (last_beat || flush_now) begin
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_reducer.sv
// Directed plus randomized bench for logic_reducer (N=4, BEATS=4) against a
// group-level reference model built from queues of per-beat results.
module tb_logic_reducer;
  import logic_pkg::*;

  localparam int N     = 4;
  localparam int BEATS = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [1:0]   op;
  logic         acc_en;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] q;

  int checks = 0;
  int errors = 0;

  // Reference model: output register plus the open group as a queue of beats.
  logic         m_ov;
  logic [N-1:0] m_q;
  logic         m_open;
  op_e          m_op;
  logic [N-1:0] m_beats[$];

  logic_reducer #(.N(N), .BEATS(BEATS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .acc_en    (acc_en),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] beat_op(input op_e o, input logic [N-1:0] x, input logic [N-1:0] y);
    case (o)
      OP_OR:   return x | y;
      OP_AND:  return x & y;
      OP_XOR:  return x ^ y;
      default: return x;
    endcase
  endfunction

  // Reduction of a whole group; PASS yields the most recent beat.
  function automatic logic [N-1:0] fold(input op_e o, input logic [N-1:0] v[$]);
    logic [N-1:0] res;
    res = v[0];
    for (int i = 1; i < v.size(); i++) begin
      case (o)
        OP_OR:   res = res | v[i];
        OP_AND:  res = res & v[i];
        OP_XOR:  res = res ^ v[i];
        default: res = v[i];
      endcase
    end
    return res;
  endfunction

  task automatic model_reset();
    m_ov   = 1'b0;
    m_q    = '0;
    m_open = 1'b0;
    m_op   = OP_OR;
    m_beats.delete();
  endtask

  task automatic model_step();
    logic         can;
    logic         was_open;
    logic         emit;
    logic [N-1:0] res;
    logic [N-1:0] rv;
    can      = !m_ov || out_ready;
    was_open = m_open;
    emit     = 1'b0;
    res      = '0;
    if (can && in_valid) begin
      rv = beat_op(was_open ? m_op : op_e'(op), a, b);
      if (!was_open && !acc_en) begin
        emit = 1'b1;
        res  = rv;
      end else begin
        if (!was_open) begin
          m_open = 1'b1;
          m_op   = op_e'(op);
          m_beats.delete();
        end
        m_beats.push_back(rv);
        if (m_beats.size() == BEATS || (was_open && flush)) begin
          emit   = 1'b1;
          res    = fold(m_op, m_beats);
          m_open = 1'b0;
        end
      end
    end else if (was_open && flush && can) begin
      emit   = 1'b1;
      res    = fold(m_op, m_beats);
      m_open = 1'b0;
    end
    if (emit) begin
      m_q  = res;
      m_ov = 1'b1;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic drive(input logic iv, input logic [N-1:0] ia, input logic [N-1:0] ib,
                       input op_e iop, input logic iacc, input logic ifl, input logic ior);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    op        = iop;
    acc_en    = iacc;
    flush     = ifl;
    out_ready = ior;
  endtask

  // One clock: check in_ready before the edge, then outputs just after it.
  task automatic cycle();
    #1;
    check("in_ready", 8'(in_ready), 8'(rst && (!m_ov || out_ready)));
    if (rst) model_step();
    else model_reset();
    @(posedge clk);
    #1;
    check("out_valid", 8'(out_valid), 8'(m_ov));
    check("q", 8'(q), 8'(m_q));
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, '0, '0, OP_OR, 1'b0, 1'b0, 1'b0);
    model_reset();
    #12;
    check("rst_out_valid", 8'(out_valid), 8'h00);
    check("rst_q", 8'(q), 8'h00);
    check("rst_in_ready", 8'(in_ready), 8'h00);
    @(negedge clk);
    rst = 1'b1;

    // Single OR
    drive(1'b1, 4'b1010, 4'b0101, OP_OR, 1'b0, 1'b0, 1'b1);
    cycle();
    check("single_or_valid", 8'(out_valid), 8'h01);
    check("single_or_q", 8'(q), 8'h0f);
    drive(1'b0, '0, '0, OP_OR, 1'b0, 1'b0, 1'b1);
    cycle();
    check("single_or_drop", 8'(out_valid), 8'h00);

    // Accumulate XOR over four beats
    for (int i = 0; i < BEATS; i++) begin
      drive(1'b1, 4'(1 << i), 4'b0000, OP_XOR, 1'b1, 1'b0, 1'b1);
      cycle();
      if (i < BEATS - 1) check("acc_xor_early", 8'(out_valid), 8'h00);
    end
    check("acc_xor_valid", 8'(out_valid), 8'h01);
    check("acc_xor_q", 8'(q), 8'h0f);
    drive(1'b0, '0, '0, OP_OR, 1'b0, 1'b0, 1'b1);
    cycle();

    // Backpressure
    drive(1'b1, 4'b0001, 4'b0000, OP_OR, 1'b0, 1'b0, 1'b0);
    cycle();
    check("bp_first_q", 8'(q), 8'h01);
    drive(1'b1, 4'b0010, 4'b0000, OP_OR, 1'b0, 1'b0, 1'b0);
    #1;
    check("bp_stall_ready", 8'(in_ready), 8'h00);
    cycle();
    check("bp_hold_valid", 8'(out_valid), 8'h01);
    check("bp_hold_q", 8'(q), 8'h01);
    out_ready = 1'b1;
    cycle();
    check("bp_release_q", 8'(q), 8'h02);
    check("bp_release_valid", 8'(out_valid), 8'h01);
    drive(1'b0, '0, '0, OP_OR, 1'b0, 1'b0, 1'b1);
    cycle();

    // Flush an AND group after two beats
    drive(1'b1, 4'b1111, 4'b1100, OP_AND, 1'b1, 1'b0, 1'b1);
    cycle();
    check("flush_no_early", 8'(out_valid), 8'h00);
    drive(1'b1, 4'b0111, 4'b1111, OP_AND, 1'b1, 1'b1, 1'b1);
    cycle();
    check("flush_q", 8'(q), 8'h04);
    check("flush_valid", 8'(out_valid), 8'h01);
    check("flush_state", 8'(dut.state), 8'(IDLE));
    drive(1'b0, '0, '0, OP_OR, 1'b0, 1'b0, 1'b1);
    cycle();

    // Reset mid-group
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 4'b1000, 4'b0000, OP_OR, 1'b1, 1'b0, 1'b1);
      cycle();
    end
    rst = 1'b0;
    #1;
    model_reset();
    check("midrst_in_ready", 8'(in_ready), 8'h00);
    check("midrst_valid", 8'(out_valid), 8'h00);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < BEATS; i++) begin
      drive(1'b1, 4'b0001, 4'b0000, OP_OR, 1'b1, 1'b0, 1'b1);
      cycle();
    end
    check("midrst_q", 8'(q), 8'h01);
    check("midrst_out", 8'(out_valid), 8'h01);

    // Op change mid-group is ignored
    for (int i = 0; i < BEATS; i++) begin
      drive(1'b1, 4'(1 << i), 4'b0000, (i == 0) ? OP_OR : OP_AND, 1'b1, 1'b0, 1'b1);
      cycle();
    end
    check("opchg_q", 8'(q), 8'h0f);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom), op_e'($urandom_range(0, 3)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
      cycle();
    end
    drive(1'b0, '0, '0, OP_OR, 1'b0, 1'b0, 1'b1);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
